// File: rtl/mbist_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mbist_pkg : states, March C- element tables and op-count helper          |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
package mbist_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [2:0] M0 = 3'd0;
  localparam logic [2:0] M1 = 3'd1;
  localparam logic [2:0] M2 = 3'd2;
  localparam logic [2:0] M3 = 3'd3;
  localparam logic [2:0] M4 = 3'd4;
  localparam logic [2:0] M5 = 3'd5;

  function automatic logic elem_down(input logic [2:0] e);
    return (e == M3) || (e == M4);
  endfunction

  function automatic logic [1:0] elem_ops(input logic [2:0] e);
    return ((e == M0) || (e == M5)) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic elem_last_op(input logic [2:0] e, input logic op);
    return {1'b0, op} == (elem_ops(e) - 2'd1);
  endfunction

  // Every element opens with a read except M0, which only writes.
  function automatic logic op_is_read(input logic [2:0] e, input logic op);
    return (e != M0) && !op;
  endfunction

  function automatic logic op_data(input logic [2:0] e, input logic op);
    case (e)
      M1, M3:  return op;
      M2, M4:  return !op;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int unsigned total_ops(input int unsigned addr_w);
    return 32'd10 << addr_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mbist_addr_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mbist_addr_gen : up/down address counter with load and terminal flag     |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module mbist_addr_gen #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic              down,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] addr,
  output logic              term
);

  localparam logic [ADDR_W-1:0] C_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load)
      addr_d = load_val;
    else if (en)
      addr_d = down ? (addr_q - C_ONE) : (addr_q + C_ONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      addr_q <= '0;
    else
      addr_q <= addr_d;
  end

  // Terminal value depends on direction, so a wrap is never mistaken for an end.
  assign term = down ? (addr_q == '0) : (addr_q == '1);
  assign addr = addr_q;

endmodule
`default_nettype wire

// File: rtl/mbist_march_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mbist_march_ctrl : March C- sequencer with read compare and fail capture |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] addr,
  output logic              we,
  output logic              re,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem
);

  logic [1:0]        state_q, state_d;
  logic [2:0]        elem_q, elem_d;
  logic              op_q, op_d;
  logic              we_q, we_d, re_q, re_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              fail_q, fail_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]        fail_elem_q, fail_elem_d;
  logic              rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0] exp_data_q, exp_data_d;
  logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
  logic [2:0]        exp_elem_q, exp_elem_d;

  logic              ag_en, ag_load, ag_down, ag_term, issue;
  logic [ADDR_W-1:0] ag_load_val, ag_addr;

  mbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (ag_en),
    .load     (ag_load),
    .down     (ag_down),
    .load_val (ag_load_val),
    .addr     (ag_addr),
    .term     (ag_term)
  );

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    op_d        = op_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    ag_en       = 1'b0;
    ag_load     = 1'b0;
    ag_load_val = '0;
    ag_down     = elem_down(elem_q);
    issue       = 1'b0;

    // The op being driven now becomes the compare context for next cycle's rdata.
    rd_vld_d   = (state_q == ST_RUN) && re_q;
    exp_data_d = wdata_q;
    exp_addr_d = ag_addr;
    exp_elem_d = elem_q;

    if (rd_vld_q && (rdata != exp_data_q) && !fail_q) begin
      fail_d      = 1'b1;
      fail_addr_d = exp_addr_q;
      fail_elem_d = exp_elem_q;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_RUN;
          elem_d      = M0;
          op_d        = 1'b0;
          ag_load     = 1'b1;
          issue       = 1'b1;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = '0;
        end
      end
      ST_RUN: begin
        if (!elem_last_op(elem_q, op_q)) begin
          op_d  = 1'b1;
          issue = 1'b1;
        end else if (!ag_term) begin
          op_d  = 1'b0;
          ag_en = 1'b1;
          issue = 1'b1;
        end else if (elem_q != M5) begin
          elem_d      = elem_q + 3'd1;
          op_d        = 1'b0;
          ag_load     = 1'b1;
          ag_load_val = elem_down(elem_q + 3'd1) ? '1 : '0;
          issue       = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase

    we_d    = issue && !op_is_read(elem_d, op_d);
    re_d    = issue && op_is_read(elem_d, op_d);
    wdata_d = issue ? {DATA_W{op_data(elem_d, op_d)}} : wdata_q;
    busy_d  = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      elem_q      <= M0;
      op_q        <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      rd_vld_q    <= 1'b0;
      exp_data_q  <= '0;
      exp_addr_q  <= '0;
      exp_elem_q  <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      op_q        <= op_d;
      we_q        <= we_d;
      re_q        <= re_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      rd_vld_q    <= rd_vld_d;
      exp_data_q  <= exp_data_d;
      exp_addr_q  <= exp_addr_d;
      exp_elem_q  <= exp_elem_d;
    end
  end

  assign addr      = ag_addr;
  assign we        = we_q;
  assign re        = re_q;
  assign wdata     = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;

endmodule
`default_nettype wire

// File: tb/tb_mbist_march_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mbist_march_ctrl : directed bench with 256x4 memory model and faults  |
// | Revision            : 1.0                                                |
// +--------------------------------------------------------------------------+
module tb_mbist_march_ctrl;

  localparam int NOPS       = 2560;
  localparam int DONE_EDGES = 2561;
  localparam int LIMIT      = 3000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] rdata = 4'h0;
  logic [7:0] addr;
  logic       we, re;
  logic [3:0] wdata;
  logic       busy, done, fail;
  logic [7:0] fail_addr;
  logic [2:0] fail_elem;

  int n_checks = 0;
  int n_fail   = 0;

  logic       sa0_en = 1'b0;
  logic       cf_en  = 1'b0;
  int         cnt10 = 0;
  int         cnt80 = 0;
  logic [3:0] mem [256];

  logic [7:0] tr_addr [NOPS];
  logic       tr_we   [NOPS];
  logic       tr_re   [NOPS];
  logic [3:0] tr_wd   [NOPS];

  int edges, strobes, both;

  mbist_march_ctrl #(.ADDR_W(8), .DATA_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rdata     (rdata),
    .addr      (addr),
    .we        (we),
    .re        (re),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem)
  );

  always #5 clk = ~clk;

  // Synchronous memory: read data appears the cycle after re.
  // Stuck-at-0 on bit 2 of 0x3C; disturb flips the 1st read of 0x10 and 4th of 0x80.
  always @(posedge clk) begin
    if (!cf_en) begin
      cnt10 <= 0;
      cnt80 <= 0;
    end
    if (we)
      mem[addr] <= (sa0_en && addr == 8'h3C) ? (wdata & 4'hB) : wdata;
    if (re) begin
      rdata <= mem[addr] ^ ((cf_en && ((addr == 8'h10 && cnt10 == 0) ||
                                       (addr == 8'h80 && cnt80 == 3))) ? 4'hF : 4'h0);
      if (cf_en && addr == 8'h10) cnt10 <= cnt10 + 1;
      if (cf_en && addr == 8'h80) cnt80 <= cnt80 + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; the next edge is E0.
  task automatic do_start(input logic hold);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = hold;
  endtask

  // Called #1 after E0; returns edges after E0 until done is seen.
  task automatic wait_done(output int n_edges, output int n_strobes, output int n_both);
    n_edges   = 0;
    n_strobes = 0;
    n_both    = 0;
    while (!done && n_edges < LIMIT) begin
      if (we && re) n_both++;
      if (we || re) begin
        if (n_strobes < NOPS) begin
          tr_addr[n_strobes] = addr;
          tr_we[n_strobes]   = we;
          tr_re[n_strobes]   = re;
          tr_wd[n_strobes]   = wdata;
        end
        n_strobes++;
      end
      @(posedge clk);
      n_edges++;
      #1;
    end
  endtask

  initial begin
    int m0_ok;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", 32'(addr), 32'h0);
    check("rst_we_re", 32'({we, re}), 32'h0);
    check("rst_wdata", 32'(wdata), 32'h0);
    check("rst_busy_done", 32'({busy, done}), 32'h0);
    check("rst_fail", 32'({fail, fail_addr, fail_elem}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_no_start", 32'({busy, done}), 32'h0);

    // Ideal memory, single start pulse
    do_start(1'b0);
    check("first_op", 32'({busy, we, re, addr, wdata}), {20'h0, 3'b110, 8'h00, 4'h0});
    wait_done(edges, strobes, both);
    check("ideal_edges", 32'(edges), 32'(DONE_EDGES));
    check("ideal_strobes", 32'(strobes), 32'(NOPS));
    check("ideal_we_and_re", 32'(both), 32'h0);
    check("ideal_fail", 32'(fail), 32'h0);
    check("ideal_done_busy", 32'({done, busy}), 32'h2);
    m0_ok = 0;
    for (int i = 0; i < 256; i++)
      if (tr_we[i] && !tr_re[i] && tr_addr[i] == 8'(i) && tr_wd[i] == 4'h0) m0_ok++;
    check("m0_trace", 32'(m0_ok), 32'd256);
    check("m1_first_r0", 32'({tr_re[256], tr_addr[256]}), {23'h0, 1'b1, 8'h00});
    check("m3_first_r0", 32'({tr_re[1280], tr_we[1280], tr_addr[1280]}), {22'h0, 2'b10, 8'hFF});
    check("m3_first_w1", 32'({tr_we[1281], tr_re[1281], tr_addr[1281], tr_wd[1281]}),
          {18'h0, 2'b10, 8'hFF, 4'hF});
    check("m4_first_r1", 32'({tr_re[1792], tr_addr[1792]}), {23'h0, 1'b1, 8'hFF});
    check("m3_last_w1", 32'({tr_we[1791], tr_addr[1791]}), {23'h0, 1'b1, 8'h00});
    check("m5_last_r0", 32'({tr_re[2559], tr_addr[2559], tr_wd[2559]}), {19'h0, 1'b1, 8'hFF, 4'h0});

    // Stuck-at-0 bit 2 at 0x3C, restart from DONE
    sa0_en = 1'b1;
    do_start(1'b0);
    check("restart_clears_done", 32'(done), 32'h0);
    wait_done(edges, strobes, both);
    check("sa0_edges", 32'(edges), 32'(DONE_EDGES));
    check("sa0_fail", 32'({fail, fail_addr, fail_elem}), {20'h0, 1'b1, 8'h3C, 3'd2});
    sa0_en = 1'b0;

    // Disturb fault: mismatches at 0x10 in M1 and 0x80 in M4, first one kept
    cf_en = 1'b1;
    do_start(1'b0);
    check("cf_fail_cleared", 32'(fail), 32'h0);
    wait_done(edges, strobes, both);
    check("cf_capture", 32'({fail, fail_addr, fail_elem}), {20'h0, 1'b1, 8'h10, 3'd1});
    cf_en = 1'b0;

    // start held high through the run
    sa0_en = 1'b1;
    do_start(1'b1);
    wait_done(edges, strobes, both);
    check("hold_edges", 32'(edges), 32'(DONE_EDGES));
    check("hold_fail", 32'({fail, fail_addr}), {23'h0, 1'b1, 8'h3C});
    @(posedge clk);
    #1;
    start = 1'b0;
    check("hold_restart", 32'({fail, done, busy, we, addr}), {20'h0, 4'b0011, 8'h00});
    wait_done(edges, strobes, both);
    check("hold_run2_edges", 32'(edges), 32'(DONE_EDGES));
    check("hold_run2_fail", 32'({fail, fail_elem}), {28'h0, 1'b1, 3'd2});
    sa0_en = 1'b0;

    // Asynchronous reset mid-run
    cf_en = 1'b1;
    do_start(1'b0);
    repeat (999) @(posedge clk);
    #1;
    check("pre_rst_state", 32'({busy, fail}), 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outs", 32'({addr, we, re, wdata, busy, done}), 32'h0);
    check("async_rst_fail", 32'({fail, fail_addr, fail_elem}), 32'h0);
    cf_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_held_outs", 32'({addr, we, re, busy, done, fail}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_start(1'b0);
    wait_done(edges, strobes, both);
    check("post_rst_edges", 32'(edges), 32'(DONE_EDGES));
    check("post_rst_strobes", 32'(strobes), 32'(NOPS));
    check("post_rst_fail", 32'(fail), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mbist_march_ctrl.md
# mbist_march_ctrl

March C- sequencer for the 256x4b MBIST wrapper. On `start`, it walks the memory address space up and down through the six March C- elements, driving address, write enable, read enable and write data, and compares returned read data against the expected background. It reports a sticky pass/fail with first-failure capture. It sits between the BIST top-level handshake and the memory under test; the memory's normal port is muxed away by the wrapper, not by this block.

## Interface
- `ADDR_W`, default 8: address width; memory depth is 2^ADDR_W.
- `DATA_W`, default 4: data width; backgrounds are all-0 and all-1.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: level, sampled only in IDLE or DONE.
- `rdata`  in  DATA_W: memory read data, valid the cycle after `re`.
- `addr`  out  ADDR_W: memory address.
- `we`  out  1: write strobe for the current cycle.
- `re`  out  1: read strobe for the current cycle.
- `wdata`  out  DATA_W: write data, all-0 or all-1.
- `busy`  out  1: high in RUN and DRAIN.
- `done`  out  1: high in DONE until the next start.
- `fail`  out  1: sticky mismatch flag, valid when `done` is high.
- `fail_addr`  out  ADDR_W: address of the first mismatching read.
- `fail_elem`  out  3: element index (0–5) of the first mismatch.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on `start`.
  - RUN→DRAIN after the last operation of M5.
  - DRAIN→DONE after one cycle.
  - DONE→RUN on `start`.
- `start` in RUN or DRAIN is ignored.
- Elements, with op order per address:
  - M0 ⇑(w0)
  - M1 ⇑(r0,w1)
  - M2 ⇑(r1,w0)
  - M3 ⇓(r0,w1)
  - M4 ⇓(r1,w0)
  - M5 ⇑(r0)
- ⇑ runs address 0 to 2^ADDR_W−1. ⇓ runs 2^ADDR_W−1 to 0.
- Exactly one operation per cycle: either `we` or `re` is high, never both, and neither is high outside RUN.
- Op index steps within an address. The address steps after the last op of the element. The element index steps when the address reaches its terminal value (all-ones for ⇑, zero for ⇓); the next element's start address is loaded in the same edge.
- Address arithmetic wraps modulo 2^ADDR_W. Terminal detect compares against the direction's end value, not a wrap.
- Expected data and address are pipelined one stage alongside `re` and compared with `rdata` in the following cycle.
- On the first mismatch: set `fail`, and latch `fail_addr` and `fail_elem`. Later mismatches do not overwrite them.
- Start from IDLE or DONE clears `fail`, `fail_addr`, `fail_elem` and `done`.
- Reset values: state IDLE; `addr`=0, `we`=0, `re`=0, `wdata`=0, `busy`=0, `done`=0, `fail`=0, `fail_addr`=0, `fail_elem`=0, and the pipeline valid bit=0.
- Reset mid-run aborts immediately to IDLE. There is no resume.

## Timing
- Edge E0 samples `start`. The first operation (w0 @ addr 0) is driven in the cycle after E0.
- Total operations: 10·2^ADDR_W, which is 2560 at defaults. They are driven in the cycles after E0 through E2559.
- The last read returns in the cycle after E2560. It is compared and captured at E2561.
- `done` rises and `busy` falls after E2561. `fail` is final at that edge.
- All outputs are registered. `rdata` is the only combinational input path, into the compare logic.
- A restart from DONE follows the same timing, with the capture registers cleared at the start edge.

## Structure
- Package `mbist_pkg` holds:
  - the state enum;
  - the element-index constants M0–M5;
  - per-element direction, op count, and per-op read/write plus data-polarity tables;
  - the total-op-count function.
- One sub-module, `mbist_addr_gen`:
  - up/down address counter with enable, synchronous load of the start address, and a terminal-count flag;
  - uses `rst_n` asynchronous reset.
- The sequencer FSM, the compare pipeline and the fail capture stay in `mbist_march_ctrl`.

## Test plan
- Ideal memory model, `start` pulsed once → `done` after exactly 2561 edges, `fail`=0, and 2560 strobes seen.
- Op trace check → M0 covers 256 writes of 0 in ascending order; M3's first op is r0 @ 0xFF, followed by w1 (`wdata`=4'hF) @ 0xFF.
- Stuck-at-0 on bit 2 of address 0x3C → `fail`=1, `fail_addr`=0x3C, `fail_elem`=2 (the first r1 read).
- Coupling fault causing two mismatches, at 0x10 in M1 and 0x80 in M4 → captured value is 0x10 / elem 1 only.
- `start` held high throughout the run → no restart until DONE. A second run then begins, with `fail` cleared at E0.
- `rst_n` asserted at cycle 1000 → all outputs reach their reset values asynchronously. A `start` after release runs a full, correct test.
